// File: rtl/std_fifo_arb_pkg.sv
// Shared types and round-robin search helper for the FIFO write arbiters.
// The search is written against a fixed upper bound so any arbiter width up to MAX_N can reuse it.
package std_fifo_arb_pkg;

    localparam int MAX_N  = 32;
    localparam int MAX_NW = 5;

    typedef enum logic {IDLE, BURST} arb_state_t;

    typedef struct packed {
        logic              found;
        logic [MAX_NW-1:0] idx;
    } rr_pick_t;

    // First valid index strictly after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0]  valid,
                                         input logic [MAX_NW-1:0] ptr,
                                         input int                n);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            j = (int'(ptr) + k) % n;
            if (k <= n && !res.found && valid[j]) begin
                res.found = 1'b1;
                res.idx   = MAX_NW'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/std_rr_pick.sv
// Round-robin priority picker: combinational, zero latency, no backpressure.
// Index ptr has lowest priority; search starts at ptr+1 and wraps.
module std_rr_pick
    import std_fifo_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int NW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [NW-1:0] ptr,
    output logic [NW-1:0] idx,
    output logic          found
);

    rr_pick_t res;

    always_comb begin
        res   = rr_pick(MAX_N'(valid), MAX_NW'(ptr), N);
        idx   = NW'(res.idx);
        found = res.found;
    end

endmodule

// File: rtl/std_fifo_wr_arb.sv
// Packet-aware round-robin arbiter onto one FIFO write port; 1-cycle grant bubble, then 1 beat/cycle.
// Backpressure: wr_full stalls the owner's beats; wr_prog_full only blocks new grants.
module std_fifo_wr_arb
    import std_fifo_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int DW       = 8,
    parameter  int MAXBURST = 16,
    localparam int NW       = $clog2(N),
    localparam int BW       = $clog2(MAXBURST + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic            fifo_wr_en,
    output logic [DW-1:0]   fifo_wr_din,
    input  logic            fifo_wr_full,
    input  logic            fifo_wr_prog_full,
    output logic            grant_valid,
    output logic [NW-1:0]   grant_id
);

    arb_state_t    state_q, state_d;
    logic [NW-1:0] grant_id_q, grant_id_d;
    logic [NW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [NW-1:0] pick_idx;
    logic          pick_found;
    logic          accept;

    std_rr_pick #(.N(N)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        accept    = 1'b0;
        req_ready = '0;
        if (state_q == BURST) begin
            accept = req_valid[grant_id_q] & ~fifo_wr_full;
        end
        req_ready[grant_id_q] = accept;
        fifo_wr_en  = accept;
        fifo_wr_din = req_data[grant_id_q*DW +: DW];
        grant_valid = (state_q == BURST);
        grant_id    = grant_id_q;
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            state_d    = IDLE;
            grant_id_d = '0;
            ptr_d      = NW'(N - 1);
            beat_cnt_d = '0;
        end else if (state_q == IDLE) begin
            if (pick_found && !fifo_wr_prog_full) begin
                state_d    = BURST;
                grant_id_d = pick_idx;
                beat_cnt_d = '0;
            end
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            // Fairness cap: a long packet is split and the owner re-competes.
            if (req_last[grant_id_q] || beat_cnt_q == BW'(MAXBURST - 1)) begin
                state_d = IDLE;
                ptr_d   = grant_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= NW'(N - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
